// File: rtl/lite_pkg.sv
// Shared types and constants for the lite_v1 fetch/decode path.
// The instruction word splits into opcode/d1/d2; HALT is a reserved opcode/d2 pair.
package lite_pkg;

  localparam int INSTR_W = 20;
  localparam int OPC_W   = 2;
  localparam int D1_W    = 8;
  localparam int D2_W    = 10;

  localparam int OPC_MSB = 19;
  localparam int OPC_LSB = 18;
  localparam int D1_MSB  = 17;
  localparam int D1_LSB  = 10;
  localparam int D2_MSB  = 9;
  localparam int D2_LSB  = 0;

  localparam logic [OPC_W-1:0] HALT_OPC = 2'b11;
  localparam logic [D2_W-1:0]  HALT_D2  = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [D1_W-1:0]  d1;
    logic [D2_W-1:0]  d2;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] word);
    instr_t i;
    i.opcode = word[OPC_MSB:OPC_LSB];
    i.d1     = word[D1_MSB:D1_LSB];
    i.d2     = word[D2_MSB:D2_LSB];
    return i;
  endfunction

  function automatic logic is_halt(input instr_t i);
    return (i.opcode == HALT_OPC) && (i.d2 == HALT_D2);
  endfunction

endpackage

// File: rtl/lite_skid_fifo.sv
// Two-entry first-word-fall-through buffer for decoded instructions.
// When empty, a push is visible at the head in the same cycle (write-through).
module lite_skid_fifo
  import lite_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  instr_t     push_data,
  input  logic       pop,
  output instr_t     head,
  output logic       head_valid,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  logic [1:0] count_reg, count_next;
  logic       wr_ptr_reg, rd_ptr_reg;
  logic       take, bypass, store;

  assign empty = (count_reg == 2'd0);
  assign full  = (count_reg == 2'd2);
  assign count = count_reg;

  // A push that is popped straight through an empty buffer never occupies a slot.
  assign take   = pop && !empty;
  assign bypass = push && pop && empty;
  assign store  = push && !bypass && (!full || take);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      instr_t slot_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          slot_reg <= '0;
        end else if (store && (wr_ptr_reg == 1'(gi))) begin
          slot_reg <= push_data;
        end
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg + {1'b0, store} - {1'b0, take};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (store) wr_ptr_reg <= ~wr_ptr_reg;
      if (take)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  always_comb begin
    head_valid = !empty || push;
    if (!empty)    head = rd_ptr_reg ? g_slot[1].slot_reg : g_slot[0].slot_reg;
    else if (push) head = push_data;
    else           head = '0;
  end

endmodule

// File: rtl/lite_fetch.sv
// Instruction fetch/decode stage: streams words from a 1-cycle-latency ROM,
// drops HALT, and hands opcode/d1/d2 downstream through a 2-entry buffer.
module lite_fetch
  import lite_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int LAST_ADDR = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [D1_W-1:0]    d1,
  output logic [D2_W-1:0]    d2,
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              pend_reg, pend_next;
  logic              halted_reg, halted_next;

  instr_t     rword, head;
  logic       ret_valid, halt_seen, push, pop, issue, credit;
  logic       fifo_full, fifo_empty, head_valid;
  logic [1:0] fifo_count;
  logic [2:0] occ;

  // Once HALT has come back, anything still returning is from a read past the end.
  assign rword     = decode(imem_rdata);
  assign ret_valid = pend_reg && !halted_reg;
  assign halt_seen = ret_valid && is_halt(rword);
  assign push      = ret_valid && !is_halt(rword);
  assign pop       = head_valid && out_ready;

  assign occ    = {1'b0, fifo_count} + {2'b00, pend_reg};
  assign credit = !fifo_full && (occ < 3'd2);

  lite_skid_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (rword),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      pc_reg     <= '0;
      pend_reg   <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      pend_reg   <= pend_next;
      halted_reg <= halted_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    pend_next   = 1'b0;
    halted_next = halted_reg || halt_seen;
    issue       = 1'b0;
    done        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = FETCH;
          pc_next     = '0;
          halted_next = 1'b0;
        end
      end
      FETCH: begin
        if (credit) begin
          issue     = 1'b1;
          pend_next = 1'b1;
          // pc parks on LAST rather than wrapping past the end of memory
          if (pc_reg == LAST) state_next = DRAIN;
          else                pc_next    = pc_reg + PC_ONE;
        end
        if (halt_seen) state_next = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && !pend_reg) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign imem_en   = issue;
  assign imem_addr = issue ? pc_reg : '0;
  assign busy      = (state_reg != IDLE);
  assign out_valid = head_valid;
  assign opcode    = head.opcode;
  assign d1        = head.d1;
  assign d2        = head.d2;

endmodule

// File: doc/lite_fetch.md
Name: lite_fetch

Overview:
Instruction fetch/decode stage that feeds the lite_v1 execute stage.
- Streams 20-bit instruction words from a synchronous instruction ROM.
- Splits each word into opcode/d1/d2 and presents them through a valid/ready interface backed by a 2-entry output buffer.
- Runs one program per start pulse. The program ends at a HALT word or at LAST_ADDR.

Parameters:
ADDR_W, 8, instruction memory address width
LAST_ADDR, 255, final address fetched if no HALT is encountered (must be < 2**ADDR_W)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (reset asserted when 0)
start  input  1  single-cycle request to run the program from address 0
imem_en  output  1  instruction memory read enable
imem_addr  output  ADDR_W  instruction memory read address
imem_rdata  input  20  read data, valid exactly 1 cycle after imem_en
out_valid  output  1  opcode/d1/d2 hold a valid instruction
out_ready  input  1  downstream accepts (tie to 1 for lite_v1)
opcode  output  2  instruction bits [19:18]
d1  output  8  instruction bits [17:10]
d2  output  10  instruction bits [9:0]
busy  output  1  program in progress (state != IDLE)
done  output  1  one-cycle pulse when the program completes

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=0, buffer empty, in-flight=0. Outputs imem_en, out_valid, busy, done = 0. imem_addr, opcode, d1, d2 = 0.
- HALT word: opcode==2'b11 and d2==10'h3FF. A HALT word is never pushed to the buffer.
- States:
  - IDLE: start=1 -> FETCH with pc=0. start in any other state is ignored.
  - FETCH: issue imem_en=1, imem_addr=pc when occupancy + in_flight < 2; then pc++. Issuing LAST_ADDR -> DRAIN. A returned HALT word -> DRAIN immediately; any read already in flight behind it is discarded and never pushed.
  - DRAIN: no further reads. When the buffer is empty and nothing is in flight -> IDLE, with done=1 for exactly that transition cycle.
- Latency: start at cycle T -> imem_en at T+1 -> data at T+2 -> out_valid=1 at T+2 (buffer write-through when empty). First-instruction latency is therefore 2 cycles after start.
- Buffer: 2 entries, first-word-fall-through. Push and pop in the same cycle when full is legal and occupancy stays 2. Overflow is impossible by the credit rule. Full throughput is 1 instruction/cycle while out_ready=1.
- Pop occurs when out_valid && out_ready. opcode/d1/d2 must stay stable while out_valid=1 and out_ready=0.
- pc is ADDR_W wide. It never wraps, because the fetch stops at LAST_ADDR.
- Decode is a pure bit split; no value checks other than HALT. Opcodes 2 and 3 (non-HALT) pass through unchanged.
- Reset mid-program: everything returns to reset values immediately. Data returning from the memory afterwards is ignored.

Decomposition:
- Package lite_pkg:
  - INSTR_W=20, OPC_W=2, D1_W=8, D2_W=10
  - field bit positions
  - HALT_OPC=2'b11, HALT_D2=10'h3FF
  - fetch state enum {IDLE, FETCH, DRAIN}
  - instruction struct {opcode, d1, d2}
- Sub-module lite_skid_fifo: 2-entry FWFT buffer with push, pop, full, empty and count, so it can be reused between later stages.

Test Plan:
- Program mem[0..3] = {00,8'hA5,0}, {01,0,10'h155}, {10,…}, HALT; out_ready=1; start once -> exactly 3 consecutive out_valid cycles (opcode 0,1,2; d1=8'hA5 on first; d2=10'h155 on second), then done pulse, busy=0.
- No HALT with LAST_ADDR=3 -> addresses 0,1,2,3 each read exactly once, 4 instructions out, done after the last pop.
- Backpressure: out_ready=0 for 5 cycles mid-stream -> at most 2 reads outstanding/buffered, imem_en held low, outputs stable; after release, no instruction lost or duplicated.
- HALT at mem[1] with out_ready=1 -> only mem[0] is output; the read of mem[2] already in flight is discarded; done fires.
- start asserted again while busy -> ignored; instruction count unchanged.
- rst=0 asserted while out_valid=1 with data in flight -> all outputs 0 in the same cycle; after release, returned data is not output; a new start restarts cleanly from address 0.
